bus_arbiter_4: RTL and testbench

//   Round-robin arbiter sharing one 4:1 bus multiplexer (Mux_4) among four requesters.

---
 rtl/bus_arbiter_4_pkg.sv | 25 ++
 rtl/bus_arbiter_4_mux.sv | 22 ++
 rtl/bus_arbiter_4.sv | 121 ++++++++++++
 tb/tb_bus_arbiter_4.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter:
// FSM state encoding, requester count and the rotating priority search.
package bus_arbiter_4_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arbState_t;

  localparam int ARB_NR_REQ = 4;

  // Returns {found, idx}. Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // The loop runs from lowest to highest priority, so the last hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] result;
    logic [1:0] idx;
    result = 3'b000;
    for (int k = ARB_NR_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) result = {1'b1, idx};
    end
    return result;
  endfunction

endpackage

// File: rtl/bus_arbiter_4_mux.sv
// Four-input bus multiplexer steered by the arbiter's registered select.
module Mux_4 #(
  parameter int NrOfBits = 32
) (
  input  logic [1:0]          Sel,
  input  logic [NrOfBits-1:0] In_0,
  input  logic [NrOfBits-1:0] In_1,
  input  logic [NrOfBits-1:0] In_2,
  input  logic [NrOfBits-1:0] In_3,
  output logic [NrOfBits-1:0] MuxOut
);

  always_comb begin
    case (Sel)
      2'd0:    MuxOut = In_0;
      2'd1:    MuxOut = In_1;
      2'd2:    MuxOut = In_2;
      default: MuxOut = In_3;
    endcase
  end

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter owning a shared 4:1 bus mux; grant and select are registered.
// Define ARB_HOLD_LIMIT_EN to preempt an owner after MaxHold cycles when others wait.
module bus_arbiter_4
  import bus_arbiter_4_pkg::*;
#(
  parameter int NrOfBits = 32,
  parameter int MaxHold  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [ARB_NR_REQ-1:0] Req,
  input  logic [NrOfBits-1:0]   In_0,
  input  logic [NrOfBits-1:0]   In_1,
  input  logic [NrOfBits-1:0]   In_2,
  input  logic [NrOfBits-1:0]   In_3,
  output logic [ARB_NR_REQ-1:0] Gnt,
  output logic [1:0]            Sel,
  output logic                  Valid,
  output logic [NrOfBits-1:0]   BusOut
);

  if (MaxHold < 1 || MaxHold > 15) begin : gBadMaxHold
    $error("MaxHold must lie in 1..15");
  end

  arbState_t             state, stateNext;
  logic [ARB_NR_REQ-1:0] gntNext, pickReq;
  logic [1:0]            selNext, ptr, ptrNext;
  logic [2:0]            pick;
  logic                  arbitrate, grantNew;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [3:0] HoldLast = 4'(MaxHold - 1);

  logic [3:0]            holdCnt;
  logic [ARB_NR_REQ-1:0] others;

  // While owning, Gnt is the owner's one-hot, so this masks the owner out.
  assign others = Req & ~Gnt;
`endif

  // Decide whether this cycle re-arbitrates and over which requests.
  always_comb begin
    arbitrate = 1'b0;
    pickReq   = Req;
    case (state)
      ARB_IDLE: arbitrate = 1'b1;
      ARB_OWN: begin
        if (!Req[Sel]) begin
          arbitrate = 1'b1;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (holdCnt == HoldLast && others != '0) begin
          arbitrate = 1'b1;
          pickReq   = others;
        end
`endif
      end
    endcase
  end

  assign pick     = rr_pick(pickReq, ptr);
  assign grantNew = arbitrate && pick[2];

  always_comb begin
    stateNext = state;
    gntNext   = Gnt;
    selNext   = Sel;
    ptrNext   = ptr;
    if (grantNew) begin
      stateNext = ARB_OWN;
      gntNext   = 4'b0001 << pick[1:0];
      selNext   = pick[1:0];
      ptrNext   = pick[1:0];
    end else if (arbitrate) begin
      // Nobody is asking: release the bus but keep Sel so BusOut stays put.
      stateNext = ARB_IDLE;
      gntNext   = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ARB_IDLE;
      Gnt   <= '0;
      Sel   <= 2'd0;
      ptr   <= 2'd3;
    end else begin
      state <= stateNext;
      Gnt   <= gntNext;
      Sel   <= selNext;
      ptr   <= ptrNext;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      holdCnt <= 4'd0;
    end else if (grantNew) begin
      holdCnt <= 4'd0;
    end else if (state == ARB_OWN && holdCnt != HoldLast) begin
      holdCnt <= holdCnt + 4'd1;
    end
  end
`endif

  assign Valid = |Gnt;

  Mux_4 #(
    .NrOfBits(NrOfBits)
  ) uMux (
    .Sel   (Sel),
    .In_0  (In_0),
    .In_1  (In_1),
    .In_2  (In_2),
    .In_3  (In_3),
    .MuxOut(BusOut)
  );

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed-vector bench for bus_arbiter_4 (MaxHold=4); follows ARB_HOLD_LIMIT_EN if defined.
module tb_bus_arbiter_4;

  localparam int NrOfBits = 32;

  logic                Clock = 1'b0;
  logic                Reset_n;
  logic [3:0]          Req;
  logic [NrOfBits-1:0] In_0, In_1, In_2, In_3;
  logic [3:0]          Gnt;
  logic [1:0]          Sel;
  logic                Valid;
  logic [NrOfBits-1:0] BusOut;

  int nVec = 0;
  int nMis = 0;

  always #5 Clock = ~Clock;

  bus_arbiter_4 #(
    .NrOfBits(NrOfBits),
    .MaxHold (4)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .Req    (Req),
    .In_0   (In_0),
    .In_1   (In_1),
    .In_2   (In_2),
    .In_3   (In_3),
    .Gnt    (Gnt),
    .Sel    (Sel),
    .Valid  (Valid),
    .BusOut (BusOut)
  );

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busFor(input logic [1:0] s);
    case (s)
      2'd0:    return In_0;
      2'd1:    return In_1;
      2'd2:    return In_2;
      default: return In_3;
    endcase
  endfunction

  task automatic expectGrant(input string tag, input logic [3:0] g, input logic [1:0] s);
    checkVec({tag, ".gnt"},   32'(Gnt),   32'(g));
    checkVec({tag, ".sel"},   32'(Sel),   32'(s));
    checkVec({tag, ".valid"}, 32'(Valid), 32'(g != 4'b0000));
    checkVec({tag, ".bus"},   BusOut,     busFor(s));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic resetDut();
    Reset_n = 1'b0;
    Req     = 4'b0000;
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  // Every-cycle invariants.
  always @(negedge Clock) begin
    checkVec("onehot0", 32'($onehot0(Gnt)), 32'd1);
    checkVec("busMux", BusOut, busFor(Sel));
  end

  initial begin
    logic [3:0] oneHot;
    logic [3:0] expG;
    int         idx;
    int         prev;

    Reset_n = 1'b0;
    Req     = 4'b0000;
    In_0    = 32'hA0A0_0001;
    In_1    = 32'hB1B1_0002;
    In_2    = 32'hC2C2_0004;
    In_3    = 32'hD3D3_0008;
    #12;
    expectGrant("rst", 4'b0000, 2'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Test 1: first grant goes to requester 0 after reset.
    Req = 4'b0101;
    tick();
    expectGrant("t1.grant", 4'b0001, 2'd0);
    tick();
    expectGrant("t1.hold", 4'b0001, 2'd0);
    In_0 = 32'h1234_5678;
    #1;
    checkVec("t1.busLive", BusOut, 32'h1234_5678);

    // Test 2: direct handoff, then release to idle with Sel kept.
    Req = 4'b0100;
    tick();
    expectGrant("t2.handoff", 4'b0100, 2'd2);
    Req = 4'b0000;
    tick();
    expectGrant("t2.idle", 4'b0000, 2'd2);
    tick();
    expectGrant("t2.idle2", 4'b0000, 2'd2);

    // Test 3: full rotation 0,1,2,3,0 with each owner holding three cycles.
    resetDut();
    Req  = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      idx    = k % 4;
      oneHot = 4'b0001 << idx;
      tick();
      expectGrant($sformatf("t3.g%0d", k), oneHot, 2'(idx));
      if (k > 0) Req[prev] = 1'b1;
      tick();
      expectGrant($sformatf("t3.h%0da", k), oneHot, 2'(idx));
      tick();
      expectGrant($sformatf("t3.h%0db", k), oneHot, 2'(idx));
      Req[idx] = 1'b0;
      prev     = idx;
    end
    tick();
    expectGrant("t3.after", 4'b0010, 2'd1);
    Req = 4'b0000;
    tick();
    expectGrant("t3.idle", 4'b0000, 2'd1);

    // Test 4: long owner with a competitor arriving one cycle in.
    resetDut();
    Req = 4'b0010;
    tick();
    expectGrant("t4.grant", 4'b0010, 2'd1);
    Req[3] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
      expG = (i == 4) ? 4'b1000 : 4'b0010;
`else
      expG = 4'b0010;
`endif
      tick();
      expectGrant($sformatf("t4.c%0d", i), expG, (expG == 4'b1000) ? 2'd3 : 2'd1);
    end
    Req[1] = 1'b0;
    tick();
    expectGrant("t4.drop", 4'b1000, 2'd3);
    Req = 4'b0000;
    tick();
    expectGrant("t4.idle", 4'b0000, 2'd3);

    // Test 5: asynchronous reset in the middle of a grant.
    Req = 4'b0100;
    tick();
    expectGrant("t5.grant", 4'b0100, 2'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    expectGrant("t5.asyncClr", 4'b0000, 2'd0);
    Req = 4'b1000;
    #2;
    Reset_n = 1'b1;
    tick();
    expectGrant("t5.first", 4'b1000, 2'd3);

    // Sole requester may be re-granted after going idle.
    Req = 4'b0000;
    tick();
    expectGrant("t5.idle", 4'b0000, 2'd3);
    Req = 4'b1000;
    tick();
    expectGrant("t5.regrant", 4'b1000, 2'd3);
    Req = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
